// File: rtl/ex_operand_stage.sv
// ex_operand_stage: execute-stage operand register with a valid/ready handshake.
// Selects A/B from rs1/pc and rs2/imm/4/0, forwards the writeback bus both at
// capture time and while an instruction is stalled, and supports flush.
module ex_operand_stage #(
  parameter int dataW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [dataW-1:0] rs1_data,
  input  logic [dataW-1:0] rs2_data,
  input  logic [dataW-1:0] imm,
  input  logic [dataW-1:0] pc,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_in,
  input  logic [3:0]       alucode_in,
  input  logic             a_sel,
  input  logic [1:0]       b_sel,
  input  logic             wen_in,
  input  logic             fwd_valid,
  input  logic [4:0]       fwd_rd,
  input  logic [dataW-1:0] fwd_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [dataW-1:0] A,
  output logic [dataW-1:0] B,
  output logic [3:0]       alucode,
  output logic [4:0]       rd,
  output logic             wen
);

  // Stored source register of each operand. Index 0 marks an operand that did
  // not come from the register file (pc, imm, constants, or x0), and because
  // forwarding ignores fwd_rd==0 such an operand can never be overwritten.
  logic [4:0]       a_src;
  logic [4:0]       b_src;
  logic [4:0]       a_src_next;
  logic [4:0]       b_src_next;
  logic [dataW-1:0] rs1_fwd;
  logic [dataW-1:0] rs2_fwd;
  logic [dataW-1:0] a_next;
  logic [dataW-1:0] b_next;
  logic             load;
  logic             a_hit;
  logic             b_hit;

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign load     = in_valid && in_ready;

  // Resolve the register-file operands against the writeback bus; x0 reads zero.
  always_comb begin
    rs1_fwd = rs1_data;
    if (rs1_addr == 5'd0) begin
      rs1_fwd = '0;
    end else if (fwd_valid && (fwd_rd == rs1_addr)) begin
      rs1_fwd = fwd_data;
    end
    rs2_fwd = rs2_data;
    if (rs2_addr == 5'd0) begin
      rs2_fwd = '0;
    end else if (fwd_valid && (fwd_rd == rs2_addr)) begin
      rs2_fwd = fwd_data;
    end
  end

  // Pick the operands to capture and remember which register each came from.
  always_comb begin
    a_next     = a_sel ? pc : rs1_fwd;
    a_src_next = a_sel ? 5'd0 : rs1_addr;
    b_next     = rs2_fwd;
    b_src_next = rs2_addr;
    case (b_sel)
      2'b00: begin
        b_next     = rs2_fwd;
        b_src_next = rs2_addr;
      end
      2'b01: begin
        b_next     = imm;
        b_src_next = 5'd0;
      end
      2'b10: begin
        b_next     = dataW'(4);
        b_src_next = 5'd0;
      end
      default: begin
        b_next     = '0;
        b_src_next = 5'd0;
      end
    endcase
  end

  // A stalled operand picks up a late writeback to the register it was read from.
  always_comb begin
    a_hit = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == a_src);
    b_hit = fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == b_src);
  end

  // Pipeline register: reset, then flush, then capture, then drain or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      wen       <= 1'b0;
      A         <= '0;
      B         <= '0;
      alucode   <= 4'd0;
      rd        <= 5'd0;
      a_src     <= 5'd0;
      b_src     <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      wen       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      wen       <= wen_in && (rd_in != 5'd0);
      A         <= a_next;
      B         <= b_next;
      alucode   <= alucode_in;
      rd        <= rd_in;
      a_src     <= a_src_next;
      b_src     <= b_src_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (a_hit) begin
        A <= fwd_data;
      end
      if (b_hit) begin
        B <= fwd_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenario bench for the execute operand stage.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_in;
  logic [3:0]  alucode_in;
  logic        a_sel;
  logic [1:0]  b_sel;
  logic        wen_in;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  alucode;
  logic [4:0]  rd;
  logic        wen;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.dataW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_in(rd_in),
    .alucode_in(alucode_in), .a_sel(a_sel), .b_sel(b_sel), .wen_in(wen_in),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .A(A), .B(B), .alucode(alucode), .rd(rd), .wen(wen)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] r1a, input logic [31:0] r1d,
                               input logic [4:0] r2a, input logic [31:0] r2d,
                               input logic [31:0] im, input logic [31:0] p,
                               input logic [4:0] rdi, input logic [3:0] alu,
                               input logic as, input logic [1:0] bs, input logic w);
    in_valid   = 1'b1;
    rs1_addr   = r1a;
    rs1_data   = r1d;
    rs2_addr   = r2a;
    rs2_data   = r2d;
    imm        = im;
    pc         = p;
    rd_in      = rdi;
    alucode_in = alu;
    a_sel      = as;
    b_sel      = bs;
    wen_in     = w;
  endtask

  task automatic set_fwd(input logic v, input logic [4:0] r, input logic [31:0] d);
    fwd_valid = v;
    fwd_rd    = r;
    fwd_data  = d;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    applyStimulus(5'd2, 32'h1234, 5'd3, 32'h5678, 32'h0, 32'h0, 5'd9, 4'd5, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid got %b want 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (A !== 32'h0) begin errors++; $display("[TB] FAIL rst_a got %h want 0", A); end
    checks++; if (B !== 32'h0) begin errors++; $display("[TB] FAIL rst_b got %h want 0", B); end
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen got %b want 0", wen); end
    checks++; if ({alucode, rd} !== 9'd0) begin errors++; $display("[TB] FAIL rst_ctrl got %h want 0", {alucode, rd}); end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    applyStimulus(5'd5, 32'h10, 5'd6, 32'h99, 32'hFFFF_FFFF, 32'h40, 5'd1, 4'd0, 1'b0, 2'b01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid got %b want 1", out_valid); end
    checks++; if (A !== 32'h10) begin errors++; $display("[TB] FAIL addi_a got %h want 10", A); end
    checks++; if (B !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL addi_b got %h want ffffffff", B); end
    checks++; if ({alucode, rd, wen} !== {4'd0, 5'd1, 1'b1}) begin errors++; $display("[TB] FAIL addi_ctrl got %h want %h", {alucode, rd, wen}, {4'd0, 5'd1, 1'b1}); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL addi_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_drain got %b want 0", out_valid); end
    checks++; if (A !== 32'h10) begin errors++; $display("[TB] FAIL addi_hold_a got %h want 10", A); end
  endtask

  task automatic test_forward_load();
    out_ready = 1'b1;
    set_fwd(1'b1, 5'd3, 32'h55);
    applyStimulus(5'd4, 32'h9, 5'd3, 32'h7, 32'h0, 32'h0, 5'd1, 4'd0, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    checks++; if (A !== 32'h9) begin errors++; $display("[TB] FAIL fwd_a_nomatch got %h want 9", A); end
    checks++; if (B !== 32'h55) begin errors++; $display("[TB] FAIL fwd_b_match got %h want 55", B); end
    set_fwd(1'b1, 5'd0, 32'h55);
    applyStimulus(5'd3, 32'h9, 5'd0, 32'h7, 32'h0, 32'h0, 5'd1, 4'd0, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    checks++; if (A !== 32'h9) begin errors++; $display("[TB] FAIL fwd_rd0_a got %h want 9", A); end
    checks++; if (B !== 32'h0) begin errors++; $display("[TB] FAIL fwd_x0_b got %h want 0", B); end
    set_fwd(1'b0, 5'd3, 32'h55);
    applyStimulus(5'd0, 32'h9, 5'd3, 32'h7, 32'h0, 32'h0, 5'd1, 4'd0, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    checks++; if (A !== 32'h0) begin errors++; $display("[TB] FAIL fwd_x0_a got %h want 0", A); end
    checks++; if (B !== 32'h7) begin errors++; $display("[TB] FAIL fwd_off_b got %h want 7", B); end
    set_fwd(1'b1, 5'd3, 32'h55);
    applyStimulus(5'd3, 32'h9, 5'd3, 32'h7, 32'h3C, 32'h200, 5'd1, 4'd0, 1'b1, 2'b10, 1'b1);
    @(negedge clk);
    checks++; if (A !== 32'h200) begin errors++; $display("[TB] FAIL sel_pc_a got %h want 200", A); end
    checks++; if (B !== 32'h4) begin errors++; $display("[TB] FAIL sel_four_b got %h want 4", B); end
    applyStimulus(5'd3, 32'h9, 5'd3, 32'h7, 32'h3C, 32'h200, 5'd1, 4'd0, 1'b0, 2'b11, 1'b1);
    @(negedge clk);
    checks++; if (A !== 32'h55) begin errors++; $display("[TB] FAIL fwd_a_match got %h want 55", A); end
    checks++; if (B !== 32'h0) begin errors++; $display("[TB] FAIL sel_zero_b got %h want 0", B); end
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_stall_forward();
    out_ready = 1'b0;
    applyStimulus(5'd6, 32'h11, 5'd7, 32'h22, 32'h0, 32'h0, 5'd8, 4'd3, 1'b0, 2'b00, 1'b1);
    @(negedge clk);
    checks++; if (A !== 32'h11) begin errors++; $display("[TB] FAIL stall_load_a got %h want 11", A); end
    applyStimulus(5'd1, 32'h5A5A, 5'd2, 32'h6B6B, 32'h0, 32'h0, 5'd12, 4'd9, 1'b0, 2'b00, 1'b1);
    set_fwd(1'b1, 5'd6, 32'hAB);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (A !== 32'hAB) begin errors++; $display("[TB] FAIL stall_fwd_a got %h want ab", A); end
    checks++; if (B !== 32'h22) begin errors++; $display("[TB] FAIL stall_b_hold got %h want 22", B); end
    checks++; if ({out_valid, alucode, rd, wen} !== {1'b1, 4'd3, 5'd8, 1'b1}) begin errors++; $display("[TB] FAIL stall_ctrl got %h want %h", {out_valid, alucode, rd, wen}, {1'b1, 4'd3, 5'd8, 1'b1}); end
    set_fwd(1'b1, 5'd9, 32'hCD);
    @(negedge clk);
    checks++; if (A !== 32'hAB) begin errors++; $display("[TB] FAIL stall_nomatch_a got %h want ab", A); end
    set_fwd(1'b1, 5'd7, 32'h77);
    @(negedge clk);
    checks++; if (B !== 32'h77) begin errors++; $display("[TB] FAIL stall_fwd_b got %h want 77", B); end
    checks++; if (A !== 32'hAB) begin errors++; $display("[TB] FAIL stall_a_keep got %h want ab", A); end
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %b want 0", out_valid); end
    out_ready = 1'b0;
    applyStimulus(5'd6, 32'h11, 5'd7, 32'h22, 32'h3C, 32'h100, 5'd8, 4'd3, 1'b1, 2'b01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    set_fwd(1'b1, 5'd6, 32'hEE);
    @(negedge clk);
    checks++; if (A !== 32'h100) begin errors++; $display("[TB] FAIL stall_pc_kept got %h want 100", A); end
    set_fwd(1'b1, 5'd7, 32'hEE);
    @(negedge clk);
    checks++; if (B !== 32'h3C) begin errors++; $display("[TB] FAIL stall_imm_kept got %h want 3c", B); end
    set_fwd(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid_%0d got %b want 1", i - 1, out_valid); end
        checks++; if (A !== 32'h100 + 32'(i - 1)) begin errors++; $display("[TB] FAIL b2b_a_%0d got %h want %h", i - 1, A, 32'h100 + 32'(i - 1)); end
        checks++; if (B !== 32'(2 * (i - 1))) begin errors++; $display("[TB] FAIL b2b_b_%0d got %h want %h", i - 1, B, 32'(2 * (i - 1))); end
        checks++; if (rd !== 5'(10 + i - 1)) begin errors++; $display("[TB] FAIL b2b_rd_%0d got %0d want %0d", i - 1, rd, 10 + i - 1); end
      end
      if (i < 4) begin
        applyStimulus(5'(i + 1), 32'h100 + 32'(i), 5'd0, 32'h0, 32'(2 * i), 32'h0, 5'(10 + i), 4'd2, 1'b0, 2'b01, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    applyStimulus(5'd2, 32'h21, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 4'd1, 1'b0, 2'b11, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_valid got %b want 1", out_valid); end
    applyStimulus(5'd3, 32'h99, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 4'd6, 1'b0, 2'b11, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL flush_wen got %b want 0", wen); end
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_absent got %b want 0", out_valid); end
    checks++; if (A === 32'h99) begin errors++; $display("[TB] FAIL flush_not_captured got %h want not 99", A); end
    applyStimulus(5'd2, 32'h21, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd1, 1'b0, 2'b11, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd0_valid got %b want 1", out_valid); end
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL rd0_wen got %b want 0", wen); end
    @(negedge clk);
  endtask

  // Scenario sequence; every step advances a fixed number of cycles.
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    rs1_addr = 5'd0; rs1_data = 32'h0; rs2_addr = 5'd0; rs2_data = 32'h0;
    imm = 32'h0; pc = 32'h0; rd_in = 5'd0; alucode_in = 4'd0;
    a_sel = 1'b0; b_sel = 2'b00; wen_in = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_addi();
    test_forward_load();
    test_stall_forward();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have parameter dataW, default 32, giving the operand and result data width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  decode presents a valid instruction.
REQ-005 The block SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 The block SHALL have ports rs1_data, rs2_data, imm, pc  input  dataW each  register-file operands, sign-extended immediate, instruction PC.
REQ-007 The block SHALL have ports rs1_addr, rs2_addr, rd_in  input  5 each  source and destination register indices.
REQ-008 The block SHALL have port alucode_in  input  4  ALU function selector, passed through unmodified.
REQ-009 The block SHALL have port a_sel  input  1  0 = rs1 operand, 1 = pc.
REQ-010 The block SHALL have port b_sel  input  2  00 = rs2, 01 = imm, 10 = constant 4, 11 = constant 0.
REQ-011 The block SHALL have port wen_in  input  1  instruction writes rd.
REQ-012 The block SHALL have ports fwd_valid (1), fwd_rd (5), fwd_data (dataW)  input  writeback forwarding bus.
REQ-013 The block SHALL have port flush  input  1  discard held and incoming instruction.
REQ-014 The block SHALL have port out_ready  input  1  ALU/downstream consumes the held instruction.
REQ-015 The block SHALL have ports out_valid (1), A (dataW), B (dataW), alucode (4), rd (5), wen (1)  output  registered operands and controls to the ALU.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-017 A load SHALL occur when in_valid && in_ready; on load all outputs register the selected operands and controls, and out_valid becomes 1 on the next cycle.
REQ-018 When out_valid && out_ready && no load, out_valid SHALL become 0 on the next cycle; all other outputs hold.
REQ-019 When out_valid && !out_ready, A, B, alucode, rd, wen SHALL hold stable, except for forwarding updates per REQ-022.
REQ-020 Operand A on load SHALL be pc if a_sel=1, otherwise the forwarded rs1 value.
REQ-021 Forwarded rs value on load SHALL be fwd_data when fwd_valid && fwd_rd!=0 && fwd_rd==rs addr, else the register-file data; rs addr 0 always yields 0.
REQ-022 While held (out_valid, no load), a stored operand sourced from rs1/rs2 SHALL be replaced with fwd_data when fwd_valid && fwd_rd!=0 && fwd_rd matches its stored source index; pc, imm and constant operands are never replaced.
REQ-023 Operand B on load SHALL be the forwarded rs2 value, imm, 32'd4 or 0 per b_sel.
REQ-024 wen output SHALL be registered as wen_in && (rd_in!=0).
REQ-025 flush SHALL take priority over load and hold: next cycle out_valid=0 and wen=0; the incoming instruction is not captured.
REQ-026 Latency SHALL be exactly one cycle from accepted input to out_valid; throughput one instruction per cycle when out_ready stays high.
REQ-027 Simultaneous load and consume in the same cycle SHALL keep out_valid=1 with the new instruction's values.

Reset
REQ-028 When rst=1 at a clock edge, out_valid, wen, A, B, alucode, rd and stored source indices SHALL become 0; rst overrides flush, load and forwarding.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts (absent flush).

Verification
REQ-030 Reset: assert rst during a held valid instruction -> next cycle out_valid=0, A=0, B=0, wen=0, in_ready=1.
REQ-031 ADDI: rs1_addr=5, rs1_data=0x10, imm=0xFFFFFFFF, b_sel=01, alucode_in=ADD -> one cycle later out_valid=1, A=0x10, B=0xFFFFFFFF.
REQ-032 Forward on load: rs2_addr=3, rs2_data=7, fwd_valid=1, fwd_rd=3, fwd_data=0x55 -> B=0x55; same with fwd_rd=0 and rs2_addr=0 -> B=0.
REQ-033 Stall and forward: out_ready=0 for 3 cycles, fwd_rd matches stored rs1 with fwd_data=0xAB -> A updates to 0xAB, in_ready=0, other outputs unchanged.
REQ-034 Back-to-back: 4 instructions with in_valid=out_ready=1 -> 4 consecutive out_valid cycles in order, no bubbles.
REQ-035 Flush with in_valid=1 and held instruction -> next cycle out_valid=0, wen=0, incoming instruction absent from output; rd_in=0 with wen_in=1 -> wen=0.
